// File: rtl/cmd_issuer.sv
// Closed-page DRAM command issuer: ACT -> RD/WR -> PR per request, with periodic refresh.
// All outputs are registered; next-cycle outputs are decoded from the next state.
module cmd_issuer #(
  parameter int unsigned BL       = 8,
  parameter int unsigned BGWIDTH  = 2,
  parameter int unsigned BAWIDTH  = 2,
  parameter int unsigned ROWWIDTH = 17,
  parameter int unsigned COLWIDTH = 10,
  parameter int unsigned T_RCD    = 17,
  parameter int unsigned T_RP     = 17,
  parameter int unsigned T_RFC    = 34,
  parameter int unsigned T_WR     = 14,
  parameter int unsigned T_RTP    = 7,
  parameter int unsigned T_CWL    = 10,
  parameter int unsigned T_RAS    = 32,
  parameter int unsigned T_REFI   = 9360
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [BGWIDTH-1:0]  req_bg,
  input  logic [BAWIDTH-1:0]  req_ba,
  input  logic [ROWWIDTH-1:0] req_row,
  input  logic [COLWIDTH-1:0] req_col,
  output logic [18:0]         commands,
  output logic [BGWIDTH-1:0]  bg,
  output logic [BAWIDTH-1:0]  ba,
  output logic [ROWWIDTH-1:0] row,
  output logic [COLWIDTH-1:0] col,
  output logic                busy
);

  localparam int unsigned CmdAct   = 18;
  localparam int unsigned CmdPre   = 7;
  localparam int unsigned CmdRd    = 5;
  localparam int unsigned CmdRef   = 3;
  localparam int unsigned CmdWr    = 1;
  localparam int unsigned WrToPre  = T_CWL + BL / 2 + T_WR;
  localparam int unsigned WaitMax0 = (T_RAS > WrToPre) ? T_RAS : WrToPre;
  localparam int unsigned WaitMax  = ((WaitMax0 > T_RFC) ? WaitMax0 : T_RFC) + 1;
  localparam int unsigned WaitW    = $clog2(WaitMax + 1);
  localparam int unsigned RasW     = $clog2(T_RAS + 1);
  localparam int unsigned RefW     = $clog2(T_REFI);

  typedef enum logic [3:0] {
    StIdle, StAct, StWaitRcd, StCas, StWaitPre, StPre, StWaitRp, StRefr, StWaitRfc
  } state_e;

  state_e              state_q, state_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic [RasW-1:0]     ras_q, ras_d;
  logic [RefW-1:0]     ref_cnt_q, ref_cnt_d;
  logic                ref_pend_q, ref_pend_d;
  logic                lat_write_q, lat_write_d;
  logic [BGWIDTH-1:0]  lat_bg_q, lat_bg_d;
  logic [BAWIDTH-1:0]  lat_ba_q, lat_ba_d;
  logic [ROWWIDTH-1:0] lat_row_q, lat_row_d;
  logic [COLWIDTH-1:0] lat_col_q, lat_col_d;
  logic [18:0]         commands_d;
  logic [BGWIDTH-1:0]  bg_d;
  logic [BAWIDTH-1:0]  ba_d;
  logic [ROWWIDTH-1:0] row_d;
  logic [COLWIDTH-1:0] col_d;
  logic                busy_d, ready_d, ref_wrap, go_ref;

  // Free-running refresh interval counter; a wrap always wins over the clear on REF issue.
  always_comb begin
    ref_wrap   = (ref_cnt_q == RefW'(T_REFI - 1));
    ref_cnt_d  = ref_wrap ? '0 : ref_cnt_q + RefW'(1);
    go_ref     = (state_q == StIdle) && ref_pend_q;
    ref_pend_d = ref_wrap | (ref_pend_q & ~go_ref);
  end

  // Each wait state is left when the counter reads 0, so loads are (delay - 2).
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    ras_d       = (ras_q != '0) ? ras_q - RasW'(1) : ras_q;
    lat_write_d = lat_write_q;
    lat_bg_d    = lat_bg_q;
    lat_ba_d    = lat_ba_q;
    lat_row_d   = lat_row_q;
    lat_col_d   = lat_col_q;
    unique case (state_q)
      StIdle: begin
        if (ref_pend_q) begin
          state_d = StRefr;
        end else if (req_valid && req_ready) begin
          state_d     = StAct;
          ras_d       = RasW'(T_RAS);
          lat_write_d = req_write;
          lat_bg_d    = req_bg;
          lat_ba_d    = req_ba;
          lat_row_d   = req_row;
          lat_col_d   = req_col;
        end
      end
      StAct: begin
        state_d = StWaitRcd;
        wait_d  = WaitW'(T_RCD - 2);
      end
      StWaitRcd: begin
        if (wait_q == '0) state_d = StCas;
        else              wait_d  = wait_q - WaitW'(1);
      end
      StCas: begin
        state_d = StWaitPre;
        wait_d  = lat_write_q ? WaitW'(WrToPre - 2) : WaitW'(T_RTP - 2);
      end
      StWaitPre: begin
        // ras_q <= 1 here means tRAS is met in the cycle PR would issue.
        if (wait_q == '0 && ras_q <= RasW'(1)) state_d = StPre;
        else if (wait_q != '0)                 wait_d  = wait_q - WaitW'(1);
      end
      StPre: begin
        state_d = StWaitRp;
        wait_d  = WaitW'(T_RP - 2);
      end
      StWaitRp: begin
        if (wait_q == '0) state_d = StIdle;
        else              wait_d  = wait_q - WaitW'(1);
      end
      StRefr: begin
        state_d = StWaitRfc;
        wait_d  = WaitW'(T_RFC - 2);
      end
      StWaitRfc: begin
        if (wait_q == '0) state_d = StIdle;
        else              wait_d  = wait_q - WaitW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    commands_d = '0;
    bg_d       = bg;
    ba_d       = ba;
    row_d      = row;
    col_d      = col;
    case (state_d)
      StAct: begin
        commands_d[CmdAct] = 1'b1;
        bg_d  = lat_bg_d;
        ba_d  = lat_ba_d;
        row_d = lat_row_d;
      end
      StCas: begin
        if (lat_write_d) commands_d[CmdWr] = 1'b1;
        else             commands_d[CmdRd] = 1'b1;
        bg_d  = lat_bg_d;
        ba_d  = lat_ba_d;
        col_d = lat_col_d;
      end
      StPre: begin
        commands_d[CmdPre] = 1'b1;
        bg_d = lat_bg_d;
        ba_d = lat_ba_d;
      end
      StRefr: begin
        commands_d[CmdRef] = 1'b1;
        bg_d = '0;
        ba_d = '0;
      end
      default: ;
    endcase
    busy_d  = (state_d != StIdle);
    ready_d = (state_d == StIdle) && !ref_pend_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      ras_q       <= '0;
      ref_cnt_q   <= '0;
      ref_pend_q  <= 1'b0;
      lat_write_q <= 1'b0;
      lat_bg_q    <= '0;
      lat_ba_q    <= '0;
      lat_row_q   <= '0;
      lat_col_q   <= '0;
      commands    <= '0;
      bg          <= '0;
      ba          <= '0;
      row         <= '0;
      col         <= '0;
      busy        <= 1'b0;
      req_ready   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      ras_q       <= ras_d;
      ref_cnt_q   <= ref_cnt_d;
      ref_pend_q  <= ref_pend_d;
      lat_write_q <= lat_write_d;
      lat_bg_q    <= lat_bg_d;
      lat_ba_q    <= lat_ba_d;
      lat_row_q   <= lat_row_d;
      lat_col_q   <= lat_col_d;
      commands    <= commands_d;
      bg          <= bg_d;
      ba          <= ba_d;
      row         <= row_d;
      col         <= col_d;
      busy        <= busy_d;
      req_ready   <= ready_d;
    end
  end

endmodule
